hex_scan: RTL

Time-multiplexed scanner for a multi-digit hex display. It sits directly upstream of the hex-to-7-segment decoder: it holds a DIGITS-nibble display word, steps through the digits at a prescaled rate, and drives the current nibble to the decoder's 4-bit digit input. It also drives the matching active-low digit-enable line. New data is double-buffered and committed only at frame start, so a frame never shows a mix of old and new digits.

---
 rtl/hex_scan.sv | 92 +++++++++
 1 files changed

// File: rtl/hex_scan.sv
// Multiplexed hex display scanner; oDIG/oAN are registered and update one edge after each prescaler tick.
// No backpressure: iLOAD is always accepted. Leading-zero blanking is enabled by defining HEX_SCAN_LZB_EN.
module hex_scan #(
  parameter int DIGITS   = 4,
  parameter int PRESCALE = 50000
) (
  input  logic                  iCLK,
  input  logic                  iRST,
  input  logic [4*DIGITS-1:0]   iDATA,
  input  logic                  iLOAD,
  output logic [3:0]            oDIG,
  output logic [DIGITS-1:0]     oAN,
  output logic                  oPEND
);

  localparam int CW = $clog2(PRESCALE);
  localparam int IW = $clog2(DIGITS);
  localparam logic [CW-1:0] CNT_MAX = CW'(PRESCALE - 1);
  localparam logic [IW-1:0] IDX_MAX = IW'(DIGITS - 1);

  logic [CW-1:0]         cnt;
  logic [IW-1:0]         idx;
  logic [IW-1:0]         idxN;
  logic [4*DIGITS-1:0]   shadow;
  logic [4*DIGITS-1:0]   disp;
  logic [4*DIGITS-1:0]   dispN;
  logic                  pend;
  logic                  tick;
  logic                  commit;
  logic [3:0]            digN;
  logic [DIGITS-1:0]     anN;

  assign tick   = (cnt == CNT_MAX);
  assign idxN   = (idx == IDX_MAX) ? '0 : idx + IW'(1);
  assign commit = tick && (idxN == '0) && pend;
  assign dispN  = commit ? shadow : disp;
  assign oPEND  = pend;

  always_comb begin
    digN = 4'h0;
    anN  = '1;
    for (int k = 0; k < DIGITS; k++) begin
      if (idxN == IW'(k)) begin
        digN   = dispN[4*k +: 4];
        anN[k] = 1'b0;
      end
    end
`ifdef HEX_SCAN_LZB_EN
    begin : lzb
      logic blank;
      blank = (idxN != '0);
      // Any nonzero nibble at or above the active digit keeps it lit.
      for (int k = 0; k < DIGITS; k++) begin
        if ((IW'(k) >= idxN) && (dispN[4*k +: 4] != 4'h0)) begin
          blank = 1'b0;
        end
      end
      if (blank) begin
        anN = '1;
      end
    end
`endif
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      cnt    <= '0;
      idx    <= '0;
      shadow <= '0;
      disp   <= '0;
      pend   <= 1'b0;
      oDIG   <= 4'h0;
      oAN    <= '1;
    end else begin
      cnt  <= tick ? '0 : cnt + CW'(1);
      disp <= dispN;
      if (tick) begin
        idx  <= idxN;
        oDIG <= digN;
        oAN  <= anN;
      end
      // A load on the commit edge re-arms pend; the committed frame uses the old shadow.
      if (iLOAD) begin
        shadow <= iDATA;
        pend   <= 1'b1;
      end else if (commit) begin
        pend <= 1'b0;
      end
    end
  end

endmodule
